// File: rtl/forth_pkg.sv
// forth_pkg: shared ASCII constants, emitter state encoding and digit-count helper.
package forth_pkg;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {IDLE, CONVERT, SIGN, DIGIT, SPACE} emit_state_e;

    // Decimal digits needed for a width-bit unsigned value (1233/4096 ~ log10(2)).
    function automatic int digit_count(input int width);
        return ((width * 1233) >> 12) + 1;
    endfunction
endpackage

// File: rtl/num_emitter_if.sv
// num_emitter_if: value request and per-character handshake between CPU, emitter and UART.
interface num_emitter_if #(parameter int DATA = 32);
    logic [DATA-1:0] i_data;
    logic            i_valid;
    logic            i_next;
    logic            o_busy;
    logic [7:0]      o_char;
    logic            o_ready;
    modport master (output i_data, i_valid, i_next, input o_busy, o_char, o_ready);
    modport slave  (input i_data, i_valid, i_next, output o_busy, o_char, o_ready);
endinterface

// File: rtl/num_emitter_bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter, one bit per enabled cycle.
module bin_to_bcd
    import forth_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int DIGITS = digit_count(DATA)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_en,
    input  logic [DATA-1:0]       i_value,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);
    localparam int CW = $clog2(DATA + 1);

    logic [DATA-1:0]     sh_q;
    logic [4*DIGITS-1:0] bcd_q, adj;
    logic [CW-1:0]       cnt_q;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end

    // o_bcd already reflects the step taken this cycle, so the last step's result is visible with o_done.
    assign o_done = i_en && cnt_q == CW'(1);
    assign o_bcd  = (i_en && cnt_q != '0) ? ((adj << 1) | (4*DIGITS)'(sh_q[DATA-1])) : bcd_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (i_en) begin
            if (i_start) begin
                sh_q  <= i_value;
                bcd_q <= '0;
                cnt_q <= CW'(DATA);
            end else if (cnt_q != '0) begin
                sh_q  <= sh_q << 1;
                bcd_q <= o_bcd;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end
endmodule

// File: rtl/num_emitter.sv
// num_emitter: prints a value as decimal ASCII, MS digit first, then a space.
// NUM_EMITTER_SIGNED_EN treats the input as two's complement and adds a leading '-'.
module num_emitter
    import forth_pkg::*;
#(
    parameter int DATA = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    num_emitter_if.slave bus
);
    localparam int DIGITS = digit_count(DATA);
    localparam int IW     = $clog2(DIGITS);

    emit_state_e         state, state_d;
    logic [IW-1:0]       idx, idx_d, msd;
    logic                start, done, consume;
    logic [DATA-1:0]     mag;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          dig;
`ifdef NUM_EMITTER_SIGNED_EN
    logic                neg, neg_d;
    // Unsigned negate keeps the most negative value exact.
    assign mag = bus.i_data[DATA-1] ? -bus.i_data : bus.i_data;
`else
    assign mag = bus.i_data;
`endif

    bin_to_bcd #(.DATA(DATA), .DIGITS(DIGITS)) u_bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (start),
        .i_en    (i_en),
        .i_value (mag),
        .o_done  (done),
        .o_bcd   (bcd)
    );

    assign dig         = bcd[4*idx +: 4];
    assign consume     = bus.o_ready && bus.i_next;
    assign bus.o_busy  = state != IDLE;
    assign bus.o_ready = state == SIGN || state == DIGIT || state == SPACE;
    assign bus.o_char  = state == SIGN  ? CHAR_MINUS :
                         state == DIGIT ? (CHAR_ZERO | {4'h0, dig}) :
                         state == SPACE ? CHAR_SPACE : 8'h00;

    always_comb begin
        msd = '0;
        for (int k = 1; k < DIGITS; k++)
            if (bcd[4*k +: 4] != 4'd0) msd = IW'(k);
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        start   = 1'b0;
`ifdef NUM_EMITTER_SIGNED_EN
        neg_d   = neg;
`endif
        case (state)
            IDLE: if (bus.i_valid) begin
                start   = 1'b1;
                state_d = CONVERT;
`ifdef NUM_EMITTER_SIGNED_EN
                neg_d   = bus.i_data[DATA-1];
`endif
            end
            CONVERT: if (done) begin
                idx_d   = msd;
`ifdef NUM_EMITTER_SIGNED_EN
                state_d = neg ? SIGN : DIGIT;
`else
                state_d = DIGIT;
`endif
            end
`ifdef NUM_EMITTER_SIGNED_EN
            SIGN: if (consume) state_d = DIGIT;
`endif
            DIGIT: if (consume) begin
                if (idx == '0) state_d = SPACE;
                else idx_d = idx - IW'(1);
            end
            SPACE: if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            idx   <= '0;
`ifdef NUM_EMITTER_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else if (i_en) begin
            state <= state_d;
            idx   <= idx_d;
`ifdef NUM_EMITTER_SIGNED_EN
            neg   <= neg_d;
`endif
        end
    end
endmodule

// File: tb/tb_num_emitter.sv
// tb_num_emitter: directed and random values checked against a printf-based decimal model.
module tb_num_emitter;
    localparam int DATA = 32;

    logic clk = 1'b0;
    logic rst, en;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    num_emitter_if #(.DATA(DATA)) bus ();
    num_emitter #(.DATA(DATA)) dut (.i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus.slave));

    function automatic string exp_str(input logic [31:0] v);
`ifdef NUM_EMITTER_SIGNED_EN
        return $sformatf("%0d ", $signed(v));
`else
        return $sformatf("%0d ", v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
        end
    endtask

    // hold<0 picks a random stall per character; dis disables i_en for that many CONVERT cycles.
    task automatic emit(input logic [31:0] v, input int hold, input int dis, input bit spam);
        string got;
        int cyc, n, h;
        logic [7:0] c;
        got = "";
        @(negedge clk);
        chk("idle_busy", bus.o_busy, 0);
        bus.i_data  = v;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = spam;
        bus.i_data  = spam ? 32'd5 : v;
        chk("accept_busy", bus.o_busy, 1);
        cyc = 0;
        while (!bus.o_ready && cyc < 200) begin
            en = !(cyc >= 10 && cyc < 10 + dis);
            @(negedge clk);
            cyc++;
        end
        en = 1'b1;
        chk("latency", cyc, DATA + dis);
        n = 0;
        while (bus.o_busy && n < 20) begin
            c = bus.o_char;
            h = hold < 0 ? int'($urandom_range(0, 2)) : hold;
            repeat (h) begin
                @(negedge clk);
                chk("hold_stable", bus.o_char, c);
            end
            bus.i_next = 1'b1;
            @(negedge clk);
            bus.i_next = 1'b0;
            got = $sformatf("%s%c", got, c);
            n++;
        end
        bus.i_valid = 1'b0;
        chk_s($sformatf("emit_%0h", v), got, exp_str(v));
        chk("ready_after", bus.o_ready, 0);
        @(negedge clk);
        chk("busy_after", bus.o_busy, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        en  = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_next  = 1'b0;
        bus.i_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_char", bus.o_char, 8'h00);
        rst = 1'b0;

        emit(32'd0, 0, 0, 1'b0);
        emit(32'd42, 0, 0, 1'b0);
        emit(32'hFFFFFFFF, 0, 0, 1'b0);
`ifdef NUM_EMITTER_SIGNED_EN
        emit(32'h80000000, 0, 0, 1'b0);
        emit(32'h7FFFFFFF, 0, 0, 1'b0);
`endif
        emit(32'd123, 5, 0, 1'b0);
        emit(32'd456, 0, 7, 1'b0);
        emit(32'd999, 1, 0, 1'b1);

        @(negedge clk);
        bus.i_data  = 32'd987;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        cyc = 0;
        while (!bus.o_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_first", bus.o_char, 8'h39);
        bus.i_next = 1'b1;
        @(negedge clk);
        bus.i_next = 1'b0;
        chk("abort_second", bus.o_char, 8'h38);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", bus.o_ready, 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_char", bus.o_char, 8'h00);
        emit(32'd7, 0, 0, 1'b0);

        repeat (8) emit($urandom, -1, int'($urandom_range(0, 3)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/num_emitter.md
# num_emitter

Converts a DATA-wide value from the CPU (e.g. the result of the Forth `.` word) into decimal ASCII characters for the UART transmit path. It emits digits most-significant first, followed by one space. The block is the output-side counterpart of the parser: the parser collects characters into words, and this block expands a number back into characters under a per-character handshake.

## Interface
- `DATA`, 32: width of the input value.
- `DIGITS`, `(DATA*1233>>12)+1`: BCD digit count (10 for DATA=32). Localparam.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_en`  in  1  clock enable. When low, all state and outputs hold.
- `i_data`  in  DATA  value to print.
- `i_valid`  in  1  value request. Accepted only when `o_busy`=0.
- `o_busy`  out  1  high from the accept edge until the trailing space is consumed.
- `o_char`  out  8  ASCII character.
- `o_ready`  out  1  `o_char` is valid.
- `i_next`  in  1  consumer takes `o_char` on an edge where `o_ready`=1 and `i_next`=1.

## Operation
- Reset values: `o_busy`=0, `o_ready`=0, `o_char`=8'h00, state IDLE, BCD register 0, shift register 0, digit index 0, negative flag 0.
- **IDLE**
  - On `i_en` & `i_valid` & !`o_busy`: latch the magnitude into the shift register, clear the BCD register, set `o_busy`, go to CONVERT.
- **CONVERT**
  - Runs for exactly DATA enabled cycles, using the double-dabble algorithm.
  - Each cycle: every BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1.
  - Leaving CONVERT: the index is set to the most significant nonzero digit, or digit 0 if the value is zero. This is a combinational priority encode on the final BCD.
  - Next state: SIGN if the negative flag is set, else DIGIT.
- **SIGN**: `o_char`='-' (8'h2D), `o_ready`=1. On consume, go to DIGIT.
- **DIGIT**
  - `o_char`=8'h30+bcd[index], `o_ready`=1.
  - On consume: if index=0, go to SPACE; else decrement index.
- **SPACE**: `o_char`=8'h20, `o_ready`=1. On consume: `o_ready`=0, `o_busy`=0, go to IDLE.
- Leading zeros are never emitted. Zero prints as "0 ".
- `i_valid` while `o_busy`=1 is ignored. The value is not queued.
- `i_next` while `o_ready`=0 is ignored.
- `i_rst` in any state returns all registers to reset values on that edge. A partially emitted number is abandoned.

## Timing
- Accept on edge A.
- CONVERT occupies edges A+1 through A+DATA.
- `o_ready` is high starting in the cycle after edge A+DATA, with the first character already valid.
- Each character occupies at least 1 cycle. Back-to-back consumes (`i_next` held high) give one character per cycle.
- `o_char` stays stable while `o_ready`=1 and `i_next`=0. The producer never withdraws a character.
- `o_busy` falls on the edge that consumes the space. A new `i_valid` is accepted on the next edge at the earliest.
- Cycles with `i_en`=0 are not counted in any of the above.

## Configuration
- `NUM_EMITTER_SIGNED_EN`
  - **Defined:** `i_data` is two's complement. If the MSB is set, the negative flag is set and the magnitude is `-i_data`, taken as an unsigned DATA-bit value, so the most negative value is exact. SIGN state is reachable.
  - **Not defined:** `i_data` is unsigned. The negative flag stays 0 and SIGN state is removed.

## Structure
- Shared package `forth_pkg` holds:
  - ASCII constants: CHAR_ZERO, CHAR_MINUS, CHAR_SPACE.
  - The emitter state enum: IDLE, CONVERT, SIGN, DIGIT, SPACE.
  - A digit-count function used for `DIGITS`.
- Sub-module `bin_to_bcd` is the sequential double-dabble engine. Interface: start, enable, value, done, bcd. `num_emitter` keeps the FSM, sign handling, leading-zero encode and handshake.

## Test plan
- Input 0, `i_next` held 1:
  - Emits 8'h30, 8'h20.
  - `o_ready` first high in the cycle after edge A+32; `o_busy` low after the space.
- Input 42, then 4294967295 (macro undefined):
  - Emits "42 ", then "4294967295 " (11 characters). No leading zeros.
- With `NUM_EMITTER_SIGNED_EN` defined:
  - 32'hFFFFFFFF gives "-1 ".
  - 32'h80000000 gives "-2147483648 ".
  - 32'h7FFFFFFF gives "2147483647 ".
- Backpressure:
  - Input 123; hold `i_next`=0 for 5 cycles on each character.
  - `o_char` stays stable; the sequence is exactly '1','2','3',' '.
  - Toggle `i_en` low mid-CONVERT: the `o_ready` arrival shifts by exactly the number of disabled cycles.
- Input 999 with `i_valid` re-asserted with value 5 during emission:
  - The second request is ignored; only "999 " is emitted.
- Assert `i_rst` for one cycle after the '9' of "987 ":
  - Next cycle: `o_ready`=0, `o_busy`=0, `o_char`=8'h00.
  - A following value 7 emits "7 " cleanly.
